// File: rtl/rv32m_muldiv_unit_pkg.sv
// Shared RV32M multiply/divide types: operation, FSM state and operand/result select encodings.
package rv32m_types;

    typedef enum logic {md_mul = 1'b0, md_div = 1'b1} muldiv_op_t;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} muldiv_state_t;

    typedef enum logic {RS1_UNSIGN = 1'b0, RS1_SIGN = 1'b1} rs1signunsignmux_sel_t;
    typedef enum logic {RS2_UNSIGN = 1'b0, RS2_SIGN = 1'b1} rs2signunsignmux_sel_t;
    typedef enum logic {MUL_LOW = 1'b0, MUL_HIGH = 1'b1}    multihighlowmux_sel_t;
    typedef enum logic {DIV_QUOT = 1'b0, DIV_REM = 1'b1}    divremquotmux_sel_t;

    localparam logic [63:0] MULDIV_DIV0_QUOT = '1;

endpackage

// File: rtl/rv32m_muldiv_unit_div_step.sv
// One combinational restoring-division step: shifted partial remainder minus divisor -> remainder, quotient bit.
module rv32m_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   i_part,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic            o_qbit
);

    logic [XLEN:0] w_diff;

    // i_part < 2*divisor, so the top bit of the difference is its sign
    assign w_diff = i_part - {1'b0, i_divisor};
    assign o_qbit = ~w_diff[XLEN];
    assign o_rem  = o_qbit ? w_diff[XLEN-1:0] : i_part[XLEN-1:0];

endmodule

// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M mul/div: mul done XLEN/MUL_STEP+1 cycles after start, div XLEN+1; busy_o stalls the pipe.
// MULDIV_FAST_MUL_EN selects a single-cycle signed array multiplier; division is always iterative.
module rv32m_muldiv_unit
    import rv32m_types::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  muldiv_op_t            op_i,
    input  rs1signunsignmux_sel_t rs1_sign_i,
    input  rs2signunsignmux_sel_t rs2_sign_i,
    input  multihighlowmux_sel_t  hilo_i,
    input  divremquotmux_sel_t    remquot_i,
    input  logic [XLEN-1:0]       a_i,
    input  logic [XLEN-1:0]       b_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [XLEN-1:0]       result_o
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);

    muldiv_state_t        r_state, w_next;
    muldiv_op_t           r_op;
    multihighlowmux_sel_t r_hilo;
    divremquotmux_sel_t   r_remquot;
    logic [2*XLEN-1:0]    r_prod;
    logic [XLEN-1:0]      r_opnd, r_a, r_result;
    logic [CW-1:0]        r_cnt;
    logic                 r_neg_q, r_neg_r, r_div0, r_ovf;

    logic                 w_accept, w_done, w_sa, w_sb, w_a_neg, w_b_neg, w_div0, w_ovf;
    logic [XLEN-1:0]      w_a_mag, w_b_mag, w_rem, w_quot, w_rem_fix, w_fix_result;
    logic [2*XLEN-1:0]    w_prod_fix, w_prod_step, w_div_next;
    logic                 w_qbit;

    assign w_accept = (r_state == IDLE) && start_i && !flush_i;
    assign w_sa     = (rs1_sign_i == RS1_SIGN);
    assign w_sb     = (rs2_sign_i == RS2_SIGN);
    assign w_a_neg  = w_sa & a_i[XLEN-1];
    assign w_b_neg  = w_sb & b_i[XLEN-1];
    // Unsigned view of the magnitude is exact even for the most negative value
    assign w_a_mag  = w_a_neg ? -a_i : a_i;
    assign w_b_mag  = w_b_neg ? -b_i : b_i;
    assign w_div0   = (b_i == '0);
    assign w_ovf    = w_sa & w_sb & (a_i == {1'b1, {(XLEN-1){1'b0}}}) & (b_i == '1);

`ifdef MULDIV_FAST_MUL_EN
    logic [XLEN-1:0]          r_b;
    logic                     r_sa, r_sb;
    logic signed [2*XLEN+1:0] w_fast_prod;

    assign w_fast_prod = $signed({r_sa & r_a[XLEN-1], r_a}) * $signed({r_sb & r_b[XLEN-1], r_b});
    assign w_prod_step = w_fast_prod[2*XLEN-1:0];
    assign w_prod_fix  = (r_op == md_mul) ? r_prod : (r_neg_q ? -r_prod : r_prod);
`else
    localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / MUL_STEP - 1);

    logic [XLEN+MUL_STEP-1:0] w_pp, w_mul_upper;

    // Upper half accumulates multiplicand * low multiplier bits while the product shifts right
    assign w_pp        = {{MUL_STEP{1'b0}}, r_opnd} * {{XLEN{1'b0}}, r_prod[MUL_STEP-1:0]};
    assign w_mul_upper = {{MUL_STEP{1'b0}}, r_prod[2*XLEN-1:XLEN]} + w_pp;
    assign w_prod_step = {w_mul_upper, r_prod[XLEN-1:MUL_STEP]};
    assign w_prod_fix  = r_neg_q ? -r_prod : r_prod;
`endif

    rv32m_div_step #(.XLEN(XLEN)) u_div_step (
        .i_part    ({r_prod[2*XLEN-1:XLEN], r_prod[XLEN-1]}),
        .i_divisor (r_opnd),
        .o_rem     (w_rem),
        .o_qbit    (w_qbit)
    );
    assign w_div_next = {w_rem, r_prod[XLEN-2:0], w_qbit};

    assign w_quot    = r_div0 ? MULDIV_DIV0_QUOT[XLEN-1:0] : (r_ovf ? r_a : w_prod_fix[XLEN-1:0]);
    assign w_rem_fix = r_div0 ? r_a : (r_ovf ? '0 :
                       (r_neg_r ? -r_prod[2*XLEN-1:XLEN] : r_prod[2*XLEN-1:XLEN]));
    assign w_fix_result = (r_op == md_mul) ?
                          ((r_hilo == MUL_HIGH) ? w_prod_fix[2*XLEN-1:XLEN] : w_prod_fix[XLEN-1:0]) :
                          ((r_remquot == DIV_REM) ? w_rem_fix : w_quot);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = (op_i == md_div) ? DIV : MUL;
`ifdef MULDIV_FAST_MUL_EN
            MUL:  w_next = FIX;
`else
            MUL:  if (r_cnt == MUL_LAST) w_next = FIX;
`endif
            DIV:  if (r_cnt == DIV_LAST) w_next = FIX;
            FIX:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (flush_i && r_state != IDLE) w_next = IDLE;
    end

    always_comb begin
        w_done   = (r_state == FIX) && !flush_i;
        busy_o   = (r_state != IDLE);
        done_o   = w_done;
        result_o = w_done ? w_fix_result : r_result;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op      <= md_mul;
            r_hilo    <= MUL_LOW;
            r_remquot <= DIV_QUOT;
            r_prod    <= '0;
            r_opnd    <= '0;
            r_a       <= '0;
            r_result  <= '0;
            r_cnt     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_div0    <= 1'b0;
            r_ovf     <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
            r_b       <= '0;
            r_sa      <= 1'b0;
            r_sb      <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_op      <= op_i;
                    r_hilo    <= hilo_i;
                    r_remquot <= remquot_i;
                    r_a       <= a_i;
                    r_prod    <= {{XLEN{1'b0}}, (op_i == md_div) ? w_a_mag : w_b_mag};
                    r_opnd    <= (op_i == md_div) ? w_b_mag : w_a_mag;
                    r_neg_q   <= w_a_neg ^ w_b_neg;
                    r_neg_r   <= w_a_neg;
                    r_div0    <= (op_i == md_div) & w_div0;
                    r_ovf     <= (op_i == md_div) & w_ovf & ~w_div0;
                    // Special divides spend a single settling cycle in DIV before FIX
                    r_cnt     <= ((op_i == md_div) && (w_div0 || w_ovf)) ? DIV_LAST : '0;
`ifdef MULDIV_FAST_MUL_EN
                    r_b       <= b_i;
                    r_sa      <= w_sa;
                    r_sb      <= w_sb;
`endif
                end
                MUL: begin
                    r_prod <= w_prod_step;
                    r_cnt  <= r_cnt + 1'b1;
                end
                DIV: begin
                    r_prod <= w_div_next;
                    r_cnt  <= r_cnt + 1'b1;
                end
                FIX: if (!flush_i) r_result <= w_fix_result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Directed bench for rv32m_muldiv_unit: latency, signed/unsigned results, special divides, flush and reset.
module tb_rv32m_muldiv_unit;
    import rv32m_types::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;
    localparam int SPC_LAT = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start_i = 1'b0;
    muldiv_op_t            op_i = md_mul;
    rs1signunsignmux_sel_t rs1_sign_i = RS1_UNSIGN;
    rs2signunsignmux_sel_t rs2_sign_i = RS2_UNSIGN;
    multihighlowmux_sel_t  hilo_i = MUL_LOW;
    divremquotmux_sel_t    remquot_i = DIV_QUOT;
    logic [31:0]           a_i = '0;
    logic [31:0]           b_i = '0;
    logic                  flush_i = 1'b0;
    logic                  busy_o, done_o;
    logic [31:0]           result_o;

    int n_cmp = 0;
    int n_err = 0;
    int lat;

    rv32m_muldiv_unit #(.XLEN(32), .MUL_STEP(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .op_i       (op_i),
        .rs1_sign_i (rs1_sign_i),
        .rs2_sign_i (rs2_sign_i),
        .hilo_i     (hilo_i),
        .remquot_i  (remquot_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .flush_i    (flush_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive a request in the current (IDLE) cycle; returns #1 into cycle T+1
    task automatic issue(input muldiv_op_t op, input rs1signunsignmux_sel_t s1,
                         input rs2signunsignmux_sel_t s2, input multihighlowmux_sel_t hl,
                         input divremquotmux_sel_t rq, input logic [31:0] a, input logic [31:0] b);
        start_i = 1'b1; op_i = op; rs1_sign_i = s1; rs2_sign_i = s2;
        hilo_i = hl; remquot_i = rq; a_i = a; b_i = b;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int k0, output int k);
        k = k0;
        while (done_o !== 1'b1 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    // Full transaction; leaves the bench #1 into the first IDLE cycle after done_o
    task automatic run(input string tag, input muldiv_op_t op, input rs1signunsignmux_sel_t s1,
                       input rs2signunsignmux_sel_t s2, input multihighlowmux_sel_t hl,
                       input divremquotmux_sel_t rq, input logic [31:0] a, input logic [31:0] b,
                       input int exp_lat, input logic [31:0] exp_res);
        int k;
        issue(op, s1, s2, hl, rq, a, b);
        chk({tag, " busy"}, {31'b0, busy_o}, 32'd1);
        wait_done(1, k);
        chk({tag, " lat"}, 32'(k), 32'(exp_lat));
        chk({tag, " res"}, result_o, exp_res);
        @(posedge clk); #1;
        chk({tag, " hold"}, result_o, exp_res);
    endtask

    initial begin
        #1 rst = 1'b0;
        #2;
        chk("rst busy", {31'b0, busy_o}, 32'd0);
        chk("rst done", {31'b0, done_o}, 32'd0);
        chk("rst result", result_o, 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        run("mul", md_mul, RS1_SIGN, RS2_SIGN, MUL_LOW, DIV_QUOT, 32'hFFFFFFFD, 32'd7, MUL_LAT, 32'hFFFFFFEB);
        run("mulhu", md_mul, RS1_UNSIGN, RS2_UNSIGN, MUL_HIGH, DIV_QUOT, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 32'hFFFFFFFE);
        run("mulhsu", md_mul, RS1_SIGN, RS2_UNSIGN, MUL_HIGH, DIV_QUOT, 32'hFFFFFFFF, 32'd2, MUL_LAT, 32'hFFFFFFFF);
        run("mulhu16", md_mul, RS1_UNSIGN, RS2_UNSIGN, MUL_HIGH, DIV_QUOT, 32'h00010000, 32'h00030000, MUL_LAT, 32'h00000003);
        run("div", md_div, RS1_SIGN, RS2_SIGN, MUL_LOW, DIV_QUOT, 32'hFFFFFFF9, 32'd2, DIV_LAT, 32'hFFFFFFFD);
        run("rem", md_div, RS1_SIGN, RS2_SIGN, MUL_LOW, DIV_REM, 32'hFFFFFFF9, 32'd2, DIV_LAT, 32'hFFFFFFFF);
        run("div0 q", md_div, RS1_UNSIGN, RS2_UNSIGN, MUL_LOW, DIV_QUOT, 32'h00001234, 32'd0, SPC_LAT, 32'hFFFFFFFF);
        run("div0 r", md_div, RS1_UNSIGN, RS2_UNSIGN, MUL_LOW, DIV_REM, 32'h00001234, 32'd0, SPC_LAT, 32'h00001234);
        run("ovf q", md_div, RS1_SIGN, RS2_SIGN, MUL_LOW, DIV_QUOT, 32'h80000000, 32'hFFFFFFFF, SPC_LAT, 32'h80000000);
        run("ovf r", md_div, RS1_SIGN, RS2_SIGN, MUL_LOW, DIV_REM, 32'h80000000, 32'hFFFFFFFF, SPC_LAT, 32'h00000000);

        // Start pulse while busy must neither restart nor re-latch operands
        issue(md_div, RS1_UNSIGN, RS2_UNSIGN, MUL_LOW, DIV_QUOT, 32'd100, 32'd7);
        @(posedge clk); #1;
        start_i = 1'b1; op_i = md_mul; a_i = 32'd55; b_i = 32'd3;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_done(3, lat);
        chk("busy-start lat", 32'(lat), 32'(DIV_LAT));
        chk("busy-start res", result_o, 32'd14);

        // Start raised in the done cycle is ignored
        start_i = 1'b1; op_i = md_mul; a_i = 32'd9; b_i = 32'd9;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("done-start busy", {31'b0, busy_o}, 32'd0);
        chk("done-start res", result_o, 32'd14);

        // Start together with flush in IDLE is dropped
        start_i = 1'b1; flush_i = 1'b1; op_i = md_div;
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b0;
        chk("idle flush busy", {31'b0, busy_o}, 32'd0);

        // Flush mid-divide at T+5
        issue(md_div, RS1_UNSIGN, RS2_UNSIGN, MUL_LOW, DIV_REM, 32'd100, 32'd7);
        repeat (4) begin @(posedge clk); #1; end
        flush_i = 1'b1;
        chk("flush done", {31'b0, done_o}, 32'd0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("flush busy", {31'b0, busy_o}, 32'd0);
        chk("flush res", result_o, 32'd14);
        run("post-flush", md_div, RS1_UNSIGN, RS2_UNSIGN, MUL_LOW, DIV_QUOT, 32'd1000, 32'd10, DIV_LAT, 32'd100);

        // Asynchronous reset at T+10 mid-divide
        issue(md_div, RS1_UNSIGN, RS2_UNSIGN, MUL_LOW, DIV_QUOT, 32'h0000FFFF, 32'd3);
        repeat (9) begin @(posedge clk); #1; end
        #2 rst = 1'b0;
        #1;
        chk("arst busy", {31'b0, busy_o}, 32'd0);
        chk("arst done", {31'b0, done_o}, 32'd0);
        chk("arst result", result_o, 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        run("after rst", md_div, RS1_SIGN, RS2_SIGN, MUL_LOW, DIV_REM, 32'd7, 32'hFFFFFFFE, DIV_LAT, 32'd1);
        run("b2b", md_mul, RS1_UNSIGN, RS2_UNSIGN, MUL_LOW, DIV_QUOT, 32'd5, 32'd6, MUL_LAT, 32'd30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
